// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state encoding, requester IDs and hold bounds for alu_arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; favours the requester not granted last
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid0 && (!valid1 || (last_grant == ID_REQ1));
    grant[1] = valid1 && (!valid0 || (last_grant == ID_REQ0));
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters
// with a hold window before result capture and a ready/valid response port.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk_lcd,
  input  logic        resetn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [11:0] req0_control,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [11:0] req1_control,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic [11:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        busy,
  output logic [15:0] op_count
);

  if (HOLD_CYCLES < HOLD_MIN || HOLD_CYCLES > HOLD_MAX) begin : g_hold_range
    $error("alu_arbiter: HOLD_CYCLES out of range 1..15");
  end

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_e     state_q;
  state_e     state_d;
  logic       last_grant;
  logic [3:0] hold_cnt;
  logic [1:0] grant;
  logic       accept;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grants only reach the requesters from IDLE and never while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == IDLE && resetn) begin
      req0_ready = grant[0];
      req1_ready = grant[1];
    end
    accept = req0_ready || req1_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (hold_cnt == 4'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk_lcd) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_grant  <= ID_REQ1;
      hold_cnt    <= 4'd0;
      alu_control <= 12'd0;
      alu_src1    <= 32'd0;
      alu_src2    <= 32'd0;
      rsp_id      <= ID_REQ0;
      rsp_result  <= 32'd0;
      op_count    <= 16'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_control <= req1_ready ? req1_control : req0_control;
        alu_src1    <= req1_ready ? req1_src1 : req0_src1;
        alu_src2    <= req1_ready ? req1_src2 : req0_src2;
        rsp_id      <= req1_ready ? ID_REQ1 : ID_REQ0;
        last_grant  <= req1_ready ? ID_REQ1 : ID_REQ0;
        hold_cnt    <= HOLD_LOAD;
      end
      if (state_q == EXEC) begin
        if (hold_cnt == 4'd0) begin
          rsp_result <= alu_result;
        end else begin
          hold_cnt <= hold_cnt - 4'd1;
        end
      end
      if (state_q == RESP && rsp_ready) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter (HOLD_CYCLES 1 and 3 instances)
module tb_alu_arbiter;

  logic clk_lcd = 1'b0;
  always #5 clk_lcd = ~clk_lcd;

  logic        resetn;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [11:0] req0_control, req1_control, alu_control;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [31:0] alu_src1, alu_src2, alu_result, rsp_result;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] op_count;

  logic        v3, ready_3, unused_ready_3;
  logic [11:0] c3, alu_control_3;
  logic [31:0] a3, b3, alu_src1_3, alu_src2_3, alu_result_3, rsp_result_3;
  logic        rsp_valid_3, rsp_id_3, busy_3;
  logic [15:0] op_count_3;
  logic        zero1 = 1'b0;
  logic        one1 = 1'b1;
  logic [11:0] zero12 = 12'd0;
  logic [31:0] zero32 = 32'd0;

  function automatic logic [31:0] alu_fn(input logic [11:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result   = alu_fn(alu_control, alu_src1, alu_src2);
  assign alu_result_3 = alu_fn(alu_control_3, alu_src1_3, alu_src2_3);

  alu_arbiter #(.HOLD_CYCLES(1)) dut (
    .clk_lcd(clk_lcd), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.HOLD_CYCLES(3)) dut3 (
    .clk_lcd(clk_lcd), .resetn(resetn),
    .req0_valid(v3), .req0_ready(ready_3), .req0_control(c3),
    .req0_src1(a3), .req0_src2(b3),
    .req1_valid(zero1), .req1_ready(unused_ready_3), .req1_control(zero12),
    .req1_src1(zero32), .req1_src2(zero32),
    .alu_control(alu_control_3), .alu_src1(alu_src1_3), .alu_src2(alu_src2_3), .alu_result(alu_result_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(one1), .rsp_id(rsp_id_3), .rsp_result(rsp_result_3),
    .busy(busy_3), .op_count(op_count_3)
  );

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pops one expectation per handshake; op_count is sampled before its increment.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_lcd);
      if (resetn && rsp_valid && rsp_ready) begin
        resp_seen++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected actual id=%0d result=%0h required none", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_result !== e.res || op_count !== e.cnt) begin
            errors++;
            $display("FAIL rsp actual id=%0d result=%0h cnt=%0h required id=%0d result=%0h cnt=%0h",
                     rsp_id, rsp_result, op_count, e.id, e.res, e.cnt);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk_lcd); #1;
    resetn = 1'b0;
    @(posedge clk_lcd); #1;
    resetn = 1'b1;
  endtask

  task automatic accept_one(input logic which, input logic [11:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic do_push, input logic [31:0] e_res, input logic [15:0] e_cnt);
    int n = 0;
    if (which) begin
      req1_control = c; req1_src1 = a; req1_src2 = b; req1_valid = 1'b1;
    end else begin
      req0_control = c; req0_src1 = a; req0_src2 = b; req0_valid = 1'b1;
    end
    #1;
    while (!(which ? req1_ready : req0_ready) && n < 10) begin
      @(posedge clk_lcd); #1;
      n++;
    end
    check(which ? "grant1_ready" : "grant0_ready", 32'(which ? req1_ready : req0_ready), 32'd1);
    if (do_push) sb.push_back('{id: which, res: e_res, cnt: e_cnt});
    @(posedge clk_lcd); #1;
    if (which) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk_lcd); #1;
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    int  n;
    int  base;
    bit  stable;
    resetn = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_control = '0; req1_control = '0;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;
    v3 = 1'b0; c3 = '0; a3 = '0; b3 = '0;
    fork monitor(); join_none

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_bus", {20'd0, alu_control} | alu_src1 | alu_src2 | rsp_result, 32'd0);

    // Single req0 op: ready same cycle, response two cycles after acceptance
    req0_control = 12'h001; req0_src1 = 32'd5; req0_src2 = 32'd7; req0_valid = 1'b1;
    #1;
    check("a_req0_ready_same_cycle", 32'(req0_ready), 32'd1);
    check("a_req1_ready_low", 32'(req1_ready), 32'd0);
    sb.push_back('{id: 1'b0, res: 32'd12, cnt: 16'd0});
    @(posedge clk_lcd); #1;
    req0_valid = 1'b0;
    check("a_busy_exec", 32'(busy), 32'd1);
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(posedge clk_lcd); #1;
      n++;
    end
    check("a_latency", 32'(n), 32'd2);
    @(posedge clk_lcd); #1;
    check("a_op_count", 32'(op_count), 32'd1);
    check("a_alu_src1_retained", alu_src1, 32'd5);

    // Both valid continuously: grants alternate 0,1,0,1
    do_reset();
    req0_control = 12'h001; req0_src1 = 32'd10; req0_src2 = 32'd20;
    req1_control = 12'h002; req1_src1 = 32'd50; req1_src2 = 32'd8;
    for (int i = 0; i < 4; i++)
      sb.push_back('{id: 1'(i % 2), res: (i % 2 == 0) ? 32'd30 : 32'd42, cnt: 16'(i)});
    base = resp_seen;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (resp_seen < base + 4 && n < 40) begin
      @(posedge clk_lcd); #1;
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("b_responses", 32'(resp_seen - base), 32'd4);
    check("b_op_count", 32'(op_count), 32'd4);
    check("b_sb_drained", 32'(sb.size()), 32'd0);

    // Consumer stalls for 5 cycles
    do_reset();
    rsp_ready = 1'b0;
    accept_one(1'b1, 12'h004, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 16'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk_lcd); #1;
      n++;
    end
    req0_control = 12'h008; req0_src1 = 32'd1; req0_src2 = 32'd2; req0_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_lcd); #1;
      if (!rsp_valid || rsp_id !== 1'b1 || rsp_result !== 32'hF000F000 || !busy || req0_ready || req1_ready)
        stable = 1'b0;
    end
    check("c_stall_stable", 32'(stable), 32'd1);
    check("c_stall_result", rsp_result, 32'hF000F000);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk_lcd); #1;
    check("c_busy_after", 32'(busy), 32'd0);
    check("c_op_count", 32'(op_count), 32'd1);

    // HOLD_CYCLES=3 instance: response at T+4, operands held while inputs change
    v3 = 1'b1; c3 = 12'h002; a3 = 32'd100; b3 = 32'd1;
    #1;
    check("d_ready", 32'(ready_3), 32'd1);
    @(posedge clk_lcd); #1;
    v3 = 1'b0; a3 = 32'd999; b3 = 32'd999;
    n = 1;
    stable = 1'b1;
    while (!rsp_valid_3 && n < 20) begin
      if (alu_src1_3 !== 32'd100 || alu_src2_3 !== 32'd1) stable = 1'b0;
      @(posedge clk_lcd); #1;
      n++;
    end
    check("d_latency_h3", 32'(n), 32'd4);
    check("d_src_stable", 32'(stable), 32'd1);
    check("d_result", rsp_result_3, 32'd99);
    @(posedge clk_lcd); #1;
    check("d_op_count", 32'(op_count_3), 32'd1);

    // Reset during EXEC aborts the op; req0 wins afterwards
    do_reset();
    accept_one(1'b0, 12'h001, 32'd1, 32'd2, 1'b0, 32'd0, 16'd0);
    check("e_in_exec", 32'(busy), 32'd1);
    base = resp_seen;
    resetn = 1'b0;
    req0_control = 12'h001; req0_src1 = 32'd3; req0_src2 = 32'd4;
    req1_control = 12'h002; req1_src1 = 32'd9; req1_src2 = 32'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk_lcd); #1;
    check("e_idle_after_reset", 32'(busy), 32'd0);
    check("e_ready_low_in_reset", 32'({req0_ready, req1_ready}), 32'd0);
    check("e_op_count_zero", 32'(op_count), 32'd0);
    resetn = 1'b1;
    #1;
    check("e_req0_wins", 32'({req0_ready, req1_ready}), 32'b10);
    sb.push_back('{id: 1'b0, res: 32'd7, cnt: 16'd0});
    @(posedge clk_lcd); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    check("e_one_response", 32'(resp_seen - base), 32'd1);
    check("e_op_count", 32'(op_count), 32'd1);

    // op_count wrap from preloaded FFFF
    @(posedge clk_lcd); #1;
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    #1;
    check("f_preload", 32'(op_count), 32'h0000FFFF);
    accept_one(1'b0, 12'h002, 32'd10, 32'd3, 1'b1, 32'd7, 16'hFFFF);
    wait_idle();
    check("f_wrap", 32'(op_count), 32'd0);
    check("f_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
